mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 9, SHALL set the word-address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL flag a pending request.
REQ-006 req_ready  output  1  SHALL flag that the block accepts a request this cycle.
REQ-007 req_write  input  1  SHALL select the request type: 1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_WIDTH  SHALL carry the word address.
REQ-009 req_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-010 rsp_valid  output  1  SHALL flag valid read data.
REQ-011 rsp_ready  input  1  SHALL flag that the consumer takes the response.
REQ-012 rsp_rdata  output  DATA_WIDTH  SHALL carry the read data.
REQ-013 ram_read_address  output  ADDR_WIDTH  SHALL drive the RAM read address.
REQ-014 ram_write_address  output  ADDR_WIDTH  SHALL drive the RAM write address.
REQ-015 ram_write  output  1  SHALL drive the RAM write enable.
REQ-016 ram_din  output  DATA_WIDTH  SHALL drive the RAM write data.
REQ-017 ram_dout  input  DATA_WIDTH  SHALL take the RAM read data, which the RAM registers one edge after it samples the read address.

Function
REQ-018 The block SHALL use the FSM states IDLE, WRITE, RD_ADDR, RD_DATA and RESP; all outputs SHALL be registered or decoded from state only.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-020 On acceptance, req_addr, req_wdata and req_write SHALL be latched; later changes to the req_* inputs SHALL have no effect until the next acceptance.
REQ-021 Accepted write: IDLE -> WRITE, with ram_write=1, ram_write_address=latched address and ram_din=latched data for exactly one cycle; then WRITE -> IDLE; no response is produced.
REQ-022 Accepted read: IDLE -> RD_ADDR, with ram_read_address=latched address; RD_ADDR -> RD_DATA unconditionally.
REQ-023 On the edge leaving RD_DATA, ram_dout SHALL be captured into rsp_rdata; RD_DATA -> RESP.
REQ-024 Read latency: rsp_valid SHALL rise after the second rising edge following the accepting edge.
REQ-025 In RESP, rsp_valid=1 and rsp_rdata SHALL be held stable until an edge with rsp_ready=1; then RESP -> IDLE and rsp_valid=0.
REQ-026 Write throughput SHALL be one write per 2 cycles; read throughput, with rsp_ready held at 1, SHALL be one read per 4 cycles.
REQ-027 ram_write SHALL be 0 in every state except WRITE.
REQ-028 ram_read_address, ram_write_address and ram_din SHALL hold their last values outside the state that drives them.
REQ-029 A read accepted right after a write to the same address SHALL return the newly written data, because the write is always committed before the read samples its address.
REQ-030 Any address in 0 to 2^ADDR_WIDTH-1 SHALL be valid; there is no wrap or range check.
REQ-031 The block SHALL never hold more than one transaction in flight.

Reset
REQ-032 While reset_n=0, the state SHALL go to IDLE immediately (asynchronously).
REQ-033 While reset_n=0, ram_write, rsp_valid, rsp_rdata, ram_read_address, ram_write_address and ram_din SHALL all be 0.
REQ-034 While reset_n=0, req_ready SHALL be 1 (IDLE).
REQ-035 Reset mid-transaction SHALL discard the transaction: no RAM write and no response.
REQ-036 After reset_n rises, the block SHALL accept a request on the first rising edge.

Verification
REQ-037 Write addr 0x005 data 0xABCD, then read addr 0x005 -> rsp_valid rises 2 edges after the read is accepted, rsp_rdata=0xABCD; ram_write is high for exactly 1 cycle.
REQ-038 Back-to-back write 0x1FF=0x1234 then read 0x1FF, with req_valid held high -> second acceptance occurs 2 cycles after the first; read returns 0x1234.
REQ-039 Read with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; one cycle after rsp_ready=1, rsp_valid=0 and req_ready=1.
REQ-040 reset_n pulsed low during RD_DATA -> all outputs 0 at once, req_ready=1, no rsp_valid afterwards; a new read of 0x005 returns 0xABCD.
REQ-041 reset_n pulsed low during WRITE to 0x010 with 0xFFFF -> ram_write drops at once; a later read of 0x010 returns the prior contents.
REQ-042 req_valid=1 while req_ready=0 (in RESP) -> the request is not accepted and the latched address and data are unchanged.

Source files
------------

// File: rtl/mem_master.sv
// Single-outstanding request bridge onto a synchronous single-port-style RAM
// with one-cycle registered read data; one write per 2 cycles, one read per 4.
module mem_master #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0] state, state_nxt;
  logic       accept;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_write ? WRITE : RD_ADDR;
      WRITE:   state_nxt = IDLE;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // The RAM-facing registers double as the request latch, so they hold
  // their values until the next accepted request of the matching type.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_read_address  <= '0;
      ram_write_address <= '0;
      ram_din           <= '0;
      rsp_rdata         <= '0;
    end else begin
      if (accept && req_write) begin
        ram_write_address <= req_addr;
        ram_din           <= req_wdata;
      end
      if (accept && !req_write) ram_read_address <= req_addr;
      if (state == RD_DATA) rsp_rdata <= ram_dout;
    end
  end

  assign req_ready = (state == IDLE);
  assign ram_write = (state == WRITE);
  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: behavioural RAM, reference memory and a read-data
// scoreboard popped whenever a response handshake is seen.
module tb_mem_master;
  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_read_address;
  logic [AW-1:0] ram_write_address;
  logic          ram_write;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  mem_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
    .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_write) mem[ram_write_address] <= ram_din;
    ram_dout <= mem[ram_read_address];
  end

  // Inputs only change just after a posedge, so a handshake seen here
  // is exactly the one the next rising edge completes.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got rdata=%h, required no response", rsp_rdata);
      end else begin
        logic [DW-1:0] exp;
        exp = sb.pop_front();
        if (rsp_rdata !== exp) begin
          n_err++;
          $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, exp);
        end
      end
    end
  end

  // Drive one request and return once the accepting edge has passed.
  // waits = negedges seen with req_ready low before acceptance.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic hold, output int waits);
    bit ok;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    waits = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
      waits++;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: req_ready=%b after %0d cycles, required 1", req_ready, waits);
    end
    @(posedge clk);
    if (w) ref_mem[a] = d;
    else   sb.push_back(ref_mem[a]);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int w;
    #12;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b, required 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    n_cmp++; if (ram_write !== 1'b0) begin n_err++; $display("FAIL rst_ram_write: got %b, required 0", ram_write); end
    n_cmp++; if (rsp_rdata !== '0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h, required 0", rsp_rdata); end
    n_cmp++; if (ram_read_address !== '0) begin n_err++; $display("FAIL rst_raddr: got %h, required 0", ram_read_address); end
    n_cmp++; if (ram_write_address !== '0) begin n_err++; $display("FAIL rst_waddr: got %h, required 0", ram_write_address); end
    n_cmp++; if (ram_din !== '0) begin n_err++; $display("FAIL rst_din: got %h, required 0", ram_din); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(1'b1, 9'h020, 16'h0BEE, 1'b0, w);
    n_cmp++; if (w != 0) begin n_err++; $display("FAIL rst_first_accept: waited %0d cycles, required 0", w); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int w;
    int hi;
    send(1'b1, 9'h005, 16'hABCD, 1'b0, w);
    @(negedge clk);
    n_cmp++; if (ram_write_address !== 9'h005 || ram_din !== 16'hABCD) begin
      n_err++; $display("FAIL wr_bus: got addr=%h din=%h, required 005/abcd", ram_write_address, ram_din);
    end
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (ram_write) hi++;
      @(negedge clk);
    end
    n_cmp++; if (hi != 1) begin n_err++; $display("FAIL wr_pulse_len: got %0d cycles, required 1", hi); end
    @(posedge clk); #1;
    send(1'b0, 9'h005, 16'h0000, 1'b0, w);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_early_valid: edge %0d got %b, required 0", i, rsp_valid); end
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_latency: got rsp_valid=%b, required 1", rsp_valid); end
    n_cmp++; if (ram_read_address !== 9'h005) begin n_err++; $display("FAIL rd_addr: got %h, required 005", ram_read_address); end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    send(1'b1, 9'h1FF, 16'h1234, 1'b1, w);
    send(1'b0, 9'h1FF, 16'h0000, 1'b1, w);
    n_cmp++; if (w != 1) begin n_err++; $display("FAIL b2b_write_gap: got %0d stall cycles, required 1", w); end
    send(1'b0, 9'h020, 16'h0000, 1'b0, w);
    n_cmp++; if (w != 3) begin n_err++; $display("FAIL b2b_read_gap: got %0d stall cycles, required 3", w); end
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    int i;
    rsp_ready = 1'b0;
    send(1'b0, 9'h005, 16'h0000, 1'b0, w);
    for (i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_timeout: got %b, required 1", rsp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h0AA; req_wdata = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hABCD || req_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold: cyc %0d valid=%b rdata=%h req_ready=%b, required 1/abcd/0", k, rsp_valid, rsp_rdata, req_ready);
      end
      n_cmp++;
      if (ram_write !== 1'b0 || ram_read_address !== 9'h005 || ram_write_address !== 9'h1FF || ram_din !== 16'h1234) begin
        n_err++; $display("FAIL bp_latched: we=%b raddr=%h waddr=%h din=%h, required 0/005/1ff/1234", ram_write, ram_read_address, ram_write_address, ram_din);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    int seen;
    logic [DW-1:0] prior;
    send(1'b0, 9'h005, 16'h0000, 1'b0, w);
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    void'(sb.pop_back());
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || ram_read_address !== '0 ||
        ram_write_address !== '0 || ram_din !== '0 || ram_write !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_rd: rdy=%b v=%b rd=%h ra=%h wa=%h din=%h we=%b, required 1/0/0/0/0/0/0",
                        req_ready, rsp_valid, rsp_rdata, ram_read_address, ram_write_address, ram_din, ram_write);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_mid_stale_rsp: got %0d valid cycles, required 0", seen); end
    @(posedge clk); #1;
    send(1'b0, 9'h005, 16'h0000, 1'b0, w);
    drain();

    prior = ref_mem[9'h010];
    send(1'b1, 9'h010, 16'hFFFF, 1'b0, w);
    ref_mem[9'h010] = prior;
    n_cmp++; if (ram_write !== 1'b1) begin n_err++; $display("FAIL rst_mid_wr_pre: ram_write=%b, required 1", ram_write); end
    reset_n = 1'b0; #1;
    n_cmp++; if (ram_write !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr_drop: ram_write=%b, required 0", ram_write); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(1'b0, 9'h010, 16'h0000, 1'b0, w);
    drain();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i * 3 + 16'h0100);
      ref_mem[i] = DW'(i * 3 + 16'h0100);
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule
